// File: rtl/vm_vending_machine.sv
// -----------------------------------------------------------------------------
// vm_vending_machine
// Vending-machine controller for a 32-slot machine. It holds a programmable
// price table and accumulates deposits into a credit balance. It vends a slot
// when the credit covers its price, then pays out any change. On cancel it
// returns the whole credit.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   i_deposit      value of the coin/note presented this cycle
//   i_deposited    one-cycle deposit event strobe
//   i_select       slot index 0..31
//   i_selected     one-cycle selection strobe (purchase, or price write in MAINT)
//   i_price        price to program for i_select (MAINT only)
//   i_cancel       request full refund of credit
//   i_maintenance  level, enters/holds price-programming mode
//   o_refund       pulse: change of o_balance units dispensed after a vend
//   o_refundall    pulse: full credit of o_balance units returned on cancel
//   o_depositall   pulse: previous cycle's deposit was rejected and returned
//   o_product      dispensed slot, non-zero only while in VEND
//   o_balance      current credit, or the amount being paid out
//   o_state        FSM state code
// -----------------------------------------------------------------------------
module vm_vending_machine (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] i_deposit,
  input  logic       i_deposited,
  input  logic [4:0] i_select,
  input  logic       i_selected,
  input  logic [9:0] i_price,
  input  logic       i_cancel,
  input  logic       i_maintenance,
  output logic       o_refund,
  output logic       o_refundall,
  output logic       o_depositall,
  output logic [4:0] o_product,
  output logic [9:0] o_balance,
  output logic [2:0] o_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CREDIT = 3'd1;
  localparam logic [2:0] S_VEND   = 3'd2;
  localparam logic [2:0] S_CHANGE = 3'd3;
  localparam logic [2:0] S_CANCEL = 3'd4;
  localparam logic [2:0] S_MAINT  = 3'd5;

  logic [2:0] r_state;
  logic [9:0] r_balance;
  logic [4:0] r_product;
  logic       r_refund;
  logic       r_refundall;
  logic       r_depositall;
  logic [9:0] r_price [32];

  logic [9:0]  w_sel_price;
  logic [10:0] w_sum;
  logic        w_can_buy;
  logic        w_new_coin;

  assign w_sel_price = r_price[i_select];
  // Carry bit of the 11-bit sum flags a balance that would exceed 1023.
  assign w_sum       = {1'b0, r_balance} + {1'b0, i_deposit};
  assign w_can_buy   = i_selected && (w_sel_price != 10'd0) && (r_balance >= w_sel_price);
  assign w_new_coin  = i_deposited && (i_deposit != 10'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_balance    <= '0;
      r_product    <= '0;
      r_refund     <= 1'b0;
      r_refundall  <= 1'b0;
      r_depositall <= 1'b0;
    end else begin
      // NOTE: pulses default low here and are overridden below; with
      // non-blocking assignments the last write in the block wins, so each
      // pulse lasts exactly one cycle without extra clearing logic.
      r_refund     <= 1'b0;
      r_refundall  <= 1'b0;
      r_depositall <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_balance <= '0;
          r_product <= '0;
          if (i_maintenance) begin
            r_state      <= S_MAINT;
            r_depositall <= i_deposited;
          end else if (w_new_coin) begin
            r_balance <= i_deposit;
            r_state   <= S_CREDIT;
          end
        end
        S_CREDIT: begin
          // A coin arriving with a cancel or a successful vend cannot be
          // credited, so it is handed back rather than swallowed.
          if (i_cancel) begin
            r_state      <= S_CANCEL;
            r_refundall  <= 1'b1;
            r_depositall <= i_deposited;
          end else if (w_can_buy) begin
            r_state      <= S_VEND;
            r_product    <= i_select;
            r_balance    <= r_balance - w_sel_price;
            r_depositall <= i_deposited;
          end else if (w_new_coin) begin
            if (!w_sum[10]) r_balance    <= w_sum[9:0];
            else            r_depositall <= 1'b1;
          end
        end
        S_VEND: begin
          r_product    <= '0;
          r_depositall <= i_deposited;
          if (r_balance != 10'd0) begin
            r_state  <= S_CHANGE;
            r_refund <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CHANGE, S_CANCEL: begin
          r_state      <= S_IDLE;
          r_balance    <= '0;
          r_depositall <= i_deposited;
        end
        S_MAINT: begin
          r_depositall <= i_deposited;
          if (!i_maintenance) r_state <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          r_balance <= '0;
          r_product <= '0;
        end
      endcase
    end
  end

  // Price table. A write issued in the cycle maintenance drops is still taken
  // because the qualifier is the current state, not the level input.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the price table is a register array cleared on reset, because
      // a zero price marks a slot unavailable; a RAM macro could not be
      // cleared in one cycle like this.
      for (int i = 0; i < 32; i++) r_price[i] <= '0;
    end else if ((r_state == S_MAINT) && i_selected) begin
      r_price[i_select] <= i_price;
    end
  end

  assign o_state      = r_state;
  assign o_balance    = r_balance;
  assign o_product    = r_product;
  assign o_refund     = r_refund;
  assign o_refundall  = r_refundall;
  assign o_depositall = r_depositall;

endmodule

// File: tb/tb_vm_vending_machine.sv
// -----------------------------------------------------------------------------
// tb_vm_vending_machine
// Directed walk through the vending scenarios followed by randomized traffic.
// A transaction-level reference model (integer credit, integer price array,
// phase number) predicts every output on every cycle.
// -----------------------------------------------------------------------------
module tb_vm_vending_machine;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] deposit;
  logic       deposited;
  logic [4:0] select;
  logic       selected;
  logic [9:0] price;
  logic       cancel;
  logic       maintenance;
  logic       refund, refundall, depositall;
  logic [4:0] product;
  logic [9:0] balance;
  logic [2:0] state;

  vm_vending_machine dut (
    .clk          (clk),
    .rst          (rst),
    .i_deposit    (deposit),
    .i_deposited  (deposited),
    .i_select     (select),
    .i_selected   (selected),
    .i_price      (price),
    .i_cancel     (cancel),
    .i_maintenance(maintenance),
    .o_refund     (refund),
    .o_refundall  (refundall),
    .o_depositall (depositall),
    .o_product    (product),
    .o_balance    (balance),
    .o_state      (state)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 holding credit, 2 vending, 3 paying
  // change, 4 returning credit, 5 programming prices.
  int m_phase, m_credit, m_slot;
  int m_ref, m_refall, m_reject;
  int m_price [32];

  task automatic model_step();
    int nphase  = m_phase;
    int ncredit = m_credit;
    int nslot   = m_slot;
    int coin    = deposited ? int'(deposit) : 0;
    int cost    = m_price[select];
    m_ref = 0; m_refall = 0; m_reject = 0;
    if (rst) begin
      nphase = 0; ncredit = 0; nslot = 0;
      foreach (m_price[i]) m_price[i] = 0;
    end else begin
      case (m_phase)
        0: begin
          ncredit = 0; nslot = 0;
          if (maintenance) begin nphase = 5; m_reject = deposited; end
          else if (coin > 0) begin ncredit = coin; nphase = 1; end
        end
        1: begin
          if (cancel) begin
            nphase = 4; m_refall = 1; m_reject = deposited;
          end else if (selected && cost > 0 && m_credit >= cost) begin
            nphase = 2; nslot = select; ncredit = m_credit - cost; m_reject = deposited;
          end else if (coin > 0) begin
            if (m_credit + coin <= 1023) ncredit = m_credit + coin;
            else m_reject = 1;
          end
        end
        2: begin
          nslot = 0; m_reject = deposited;
          if (m_credit > 0) begin nphase = 3; m_ref = 1; end
          else nphase = 0;
        end
        3, 4: begin nphase = 0; ncredit = 0; m_reject = deposited; end
        default: begin
          m_reject = deposited;
          if (selected) m_price[select] = int'(price);
          if (!maintenance) nphase = 0;
        end
      endcase
    end
    m_phase = nphase; m_credit = ncredit; m_slot = nslot;
  endtask

  task automatic compare_all();
    check("state",      state,      m_phase);
    check("balance",    balance,    m_credit);
    check("product",    product,    m_slot);
    check("refund",     refund,     m_ref);
    check("refundall",  refundall,  m_refall);
    check("depositall", depositall, m_reject);
  endtask

  // One clock: model consumes the inputs seen at the edge, outputs are
  // compared 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic drive(input int dep, input int sel, input int pr,
                       input bit can, input bit maint);
    deposited   = (dep >= 0);
    deposit     = (dep >= 0) ? 10'(dep) : 10'd0;
    selected    = (sel >= 0);
    select      = (sel >= 0) ? 5'(sel) : 5'd0;
    price       = 10'(pr);
    cancel      = can;
    maintenance = maint;
    tick();
  endtask

  task automatic idle_cycle(input bit maint = 1'b0);
    drive(-1, -1, 0, 1'b0, maint);
  endtask

  initial begin
    rst = 1'b1;
    deposit = '0; deposited = 0; select = '0; selected = 0;
    price = '0; cancel = 0; maintenance = 0;
    m_phase = 0; m_credit = 0; m_slot = 0;
    m_ref = 0; m_refall = 0; m_reject = 0;
    foreach (m_price[i]) m_price[i] = 0;

    // Reset
    idle_cycle(); idle_cycle();
    check("rst_state", state, 0);
    check("rst_balance", balance, 0);
    check("rst_pulses", {refund, refundall, depositall}, 0);
    rst = 1'b0;
    drive(-1, 3, 0, 1'b0, 1'b0);
    check("sel_no_credit", state, 0);

    // Maintenance: last write wins
    idle_cycle(1'b1);
    check("maint_enter", state, 5);
    drive(-1, 0,  100, 1'b0, 1'b1);
    drive(-1, 31, 100, 1'b0, 1'b1);
    drive(-1, 31, 200, 1'b0, 1'b1);
    drive(-1, 3,  200, 1'b0, 1'b1);
    drive(-1, 1,  150, 1'b0, 1'b0);   // write in the leaving cycle still lands
    check("maint_exit", state, 0);
    drive(500, -1, 0, 1'b0, 1'b0);
    drive(-1, 31, 0, 1'b0, 1'b0);
    check("slot31_cost", balance, 300);
    idle_cycle(); idle_cycle();

    // Vend with change
    drive(100, -1, 0, 1'b0, 1'b0);
    check("dep100_bal", balance, 100);
    check("dep100_state", state, 1);
    drive(500, -1, 0, 1'b0, 1'b0);
    check("dep500_bal", balance, 600);
    drive(-1, 3, 0, 1'b0, 1'b0);
    check("vend_state", state, 2);
    check("vend_product", product, 3);
    check("vend_bal", balance, 400);
    idle_cycle();
    check("change_state", state, 3);
    check("change_refund", refund, 1);
    check("change_bal", balance, 400);
    idle_cycle();
    check("after_change", {state, balance}, 0);

    // Exact pay / insufficient credit (slot 1 = 150, written on exit)
    drive(100, -1, 0, 1'b0, 1'b0);
    drive(-1, 1, 0, 1'b0, 1'b0);
    check("short_credit", balance, 100);
    drive(50, -1, 0, 1'b0, 1'b0);
    drive(-1, 1, 0, 1'b0, 1'b0);
    check("exact_vend", state, 2);
    idle_cycle();
    check("exact_idle", state, 0);
    check("exact_norefund", refund, 0);

    // Cancel and overflow
    drive(500, -1, 0, 1'b0, 1'b0);
    drive(500, -1, 0, 1'b0, 1'b0);
    check("bal1000", balance, 1000);
    drive(100, -1, 0, 1'b0, 1'b0);
    check("ovf_reject", depositall, 1);
    check("ovf_bal", balance, 1000);
    drive(-1, -1, 0, 1'b1, 1'b0);
    check("cancel_state", state, 4);
    check("cancel_refundall", refundall, 1);
    check("cancel_bal", balance, 1000);
    idle_cycle();
    check("after_cancel", {state, balance}, 0);

    // Unavailable slot, deposit during maintenance
    drive(10, -1, 0, 1'b0, 1'b0);
    drive(-1, 7, 0, 1'b0, 1'b0);
    check("unavail_slot", state, 1);
    drive(-1, -1, 0, 1'b1, 1'b0);
    idle_cycle();
    idle_cycle(1'b1);
    drive(30, -1, 0, 1'b0, 1'b1);
    check("maint_dep_reject", depositall, 1);
    check("maint_dep_bal", balance, 0);
    idle_cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      int dep, sel;
      bit can;
      rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 39) == 0) maintenance = ~maintenance;
      dep = ($urandom_range(0, 2) == 0)
            ? (($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 1023))
                                          : int'($urandom_range(1, 300)))
            : -1;
      sel = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : -1;
      can = ($urandom_range(0, 14) == 0);
      drive(dep, sel, int'($urandom_range(0, 400)), can, maintenance);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
